// File: rtl/fht_bank_loader_if.sv
// Sample-stream and RAM-write bus of the FHT bank loader.
// The slave modport is the loader's view; master is the ADC/RAM side.
interface fht_bank_loader_if #(
    parameter int D_BIT     = 16,
    parameter int A_BIT     = 8,
    parameter int NUM_BANKS = 4
);
    logic                 iVALID;
    logic [D_BIT-2:0]     iDATA;
    logic                 oREADY;
    logic [NUM_BANKS-1:0] oWE;
    logic [D_BIT-1:0]     oDATA;
    logic [A_BIT-1:0]     oADDR;

    modport master (
        output iVALID, iDATA,
        input  oREADY, oWE, oDATA, oADDR
    );

    modport slave (
        input  iVALID, iDATA,
        output oREADY, oWE, oDATA, oADDR
    );
endinterface

// File: rtl/fht_bank_loader.sv
// FHT sample loader: spreads a sign-extended ADC stream over NUM_BANKS RAM banks, then starts and tracks the core.
// Optional macro FHT_LOADER_BITREV_EN adds the bit-reversed line order selected by iMODE.
module fht_bank_loader #(
    parameter int D_BIT     = 16,
    parameter int A_BIT     = 8,
    parameter int NUM_BANKS = 4
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iARM,
    input  logic                    iMODE,
    fht_bank_loader_if.slave        bus,
    output logic                    oSTART,
    input  logic                    iRDY,
    output logic                    oBUSY,
    output logic                    oDONE
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int CNT_W  = A_BIT + BANK_W;
    localparam logic [CNT_W-1:0]     LAST_CNT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_BANKS-1:0] WE_ONE   = {{(NUM_BANKS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        FIRE      = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_RDY  = 3'd4
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 mode_r;
    logic                 ready_r;
    logic [NUM_BANKS-1:0] we_r;
    logic [D_BIT-1:0]     data_r;
    logic [A_BIT-1:0]     addr_r;
    logic                 start_r;
    logic                 busy_r;
    logic                 done_r;

    logic [A_BIT-1:0]     line_s;
    logic [BANK_W-1:0]    bank_s;
    logic [A_BIT-1:0]     addr_s;
    logic                 accept_s;

`ifdef FHT_LOADER_BITREV_EN
    function automatic logic [A_BIT-1:0] bit_reverse(input logic [A_BIT-1:0] line);
        logic [A_BIT-1:0] rev;
        for (int i = 0; i < A_BIT; i++) begin
            rev[i] = line[A_BIT-1-i];
        end
        return rev;
    endfunction
`endif

    assign line_s   = cnt_r[CNT_W-1:BANK_W];
    assign bank_s   = cnt_r[BANK_W-1:0];
    assign accept_s = bus.iVALID & ready_r & (state_r == LOAD);

    // Line address of the sample currently offered, in the latched order.
    always_comb begin
        addr_s = line_s;
`ifdef FHT_LOADER_BITREV_EN
        if (mode_r) begin
            addr_s = bit_reverse(line_s);
        end else begin
            addr_s = line_s;
        end
`endif
    end

`ifndef FHT_LOADER_BITREV_EN
    logic mode_unused_s;
    assign mode_unused_s = iMODE | mode_r;
`endif

    // Load/handshake FSM with all outputs registered.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            mode_r  <= 1'b0;
            ready_r <= 1'b0;
            we_r    <= {NUM_BANKS{1'b0}};
            data_r  <= {D_BIT{1'b0}};
            addr_r  <= {A_BIT{1'b0}};
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            we_r    <= {NUM_BANKS{1'b0}};
            start_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    // done_r high means this is the exit cycle; a fresh arm is needed.
                    if (iARM && !done_r) begin
                        state_r <= LOAD;
`ifdef FHT_LOADER_BITREV_EN
                        mode_r  <= iMODE;
`else
                        mode_r  <= 1'b0;
`endif
                        cnt_r   <= {CNT_W{1'b0}};
                        ready_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        we_r   <= WE_ONE << bank_s;
                        addr_r <= addr_s;
                        data_r <= {bus.iDATA[D_BIT-2], bus.iDATA};
                        if (cnt_r == LAST_CNT) begin
                            state_r <= FIRE;
                            ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                FIRE: begin
                    start_r <= 1'b1;
                    state_r <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!iRDY) begin
                        state_r <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (iRDY) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oREADY = ready_r;
    assign bus.oWE    = we_r;
    assign bus.oDATA  = data_r;
    assign bus.oADDR  = addr_r;
    assign oSTART     = start_r;
    assign oBUSY      = busy_r;
    assign oDONE      = done_r;
endmodule

// File: tb/tb_fht_bank_loader.sv
// Directed self-checking bench for fht_bank_loader (default parameters, 1024 samples per load).
`timescale 1ns/1ps
module tb_fht_bank_loader;
    localparam int D_BIT = 16, A_BIT = 8, NUM_BANKS = 4, NSAMP = 1024, LOG_SZ = 8192;

    logic clk = 1'b0, rst = 1'b1, arm = 1'b0, mode = 1'b0, rdy = 1'b1;
    logic start, busy, done;
    int   pass_cnt = 0, check_cnt = 0;

    always #5 clk = ~clk;

    fht_bank_loader_if #(.D_BIT(D_BIT), .A_BIT(A_BIT), .NUM_BANKS(NUM_BANKS)) bus();

    fht_bank_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .NUM_BANKS(NUM_BANKS)) dut (
        .iCLK(clk), .iRESET(rst), .iARM(arm), .iMODE(mode), .bus(bus),
        .oSTART(start), .iRDY(rdy), .oBUSY(busy), .oDONE(done)
    );

    // Write/start/done logger, sampled on the falling edge.
    int cyc = 0, wr_n = 0, start_n = 0, done_n = 0, last_start_cyc = -1;
    logic [NUM_BANKS-1:0] log_we   [LOG_SZ];
    logic [A_BIT-1:0]     log_addr [LOG_SZ];
    logic [D_BIT-1:0]     log_data [LOG_SZ];
    int                   log_cyc  [LOG_SZ];

    always @(negedge clk) begin
        cyc++;
        if (bus.oWE !== 4'b0000) begin
            if (wr_n < LOG_SZ) begin
                log_we[wr_n]   = bus.oWE;
                log_addr[wr_n] = bus.oADDR;
                log_data[wr_n] = bus.oDATA;
                log_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
        if (start === 1'b1) begin
            start_n++;
            last_start_cyc = cyc;
        end
        if (done === 1'b1) done_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic m);
        arm  = 1'b1;
        mode = m;
        tick();
        arm  = 1'b0;
        mode = ~m;
    endtask

    task automatic feed(input int n, input bit gaps, input bit special, output int acc, output int stray);
        int k = 0;
        int budget = n * 4 + 100;
        bit toggle = 1'b0;
        logic valid, r;
        stray = 0;
        while (k < n && budget > 0) begin
            valid = !(gaps && toggle);
            bus.iVALID = valid;
            if (special && k == 0)      bus.iDATA = 15'h4000;
            else if (special && k == 1) bus.iDATA = 15'h3FFF;
            else                        bus.iDATA = 15'(k);
            r = bus.oREADY;
            tick();
            if (!valid && bus.oWE !== 4'b0000) stray++;
            if (valid && r === 1'b1) k++;
            toggle = ~toggle;
            budget--;
        end
        bus.iVALID = 1'b0;
        acc = k;
    endtask

    task automatic run_core(input int hold, input bit arm_mid, input bit rearm);
        int budget = 20;
        int bad = 0;
        while (start !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check_cnt++;
        if (start !== 1'b1) $display("FAIL start_seen: oSTART=%b required 1", start);
        else pass_cnt++;
        rdy = 1'b0;
        for (int i = 0; i < hold; i++) begin
            arm = arm_mid && (i == 10);
            tick();
            if (busy !== 1'b1 || done !== 1'b0 || bus.oREADY !== 1'b0) bad++;
        end
        arm = 1'b0;
        check_cnt++;
        if (bad != 0) $display("FAIL wait_busy: %0d bad cycles, required 0", bad);
        else pass_cnt++;
        rdy = 1'b1;
        budget = 10;
        while (done !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check_cnt++;
        if (done !== 1'b1) $display("FAIL done_seen: oDONE=%b required 1", done);
        else pass_cnt++;
        arm = rearm;
        tick();
        check_cnt++;
        if ({done, busy, bus.oREADY} !== 3'b000)
            $display("FAIL done_exit: done/busy/ready=%b required 000", {done, busy, bus.oREADY});
        else pass_cnt++;
        if (rearm) begin
            tick();
            arm = 1'b0;
            check_cnt++;
            if ({busy, bus.oREADY} !== 2'b11)
                $display("FAIL rearm_load: busy/ready=%b required 11", {busy, bus.oREADY});
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        int acc, stray, s0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_cnt++;
        if ({bus.oREADY, bus.oWE, bus.oDATA, bus.oADDR} !== 29'd0)
            $display("FAIL reset_bus: %h required 0", {bus.oREADY, bus.oWE, bus.oDATA, bus.oADDR});
        else pass_cnt++;
        check_cnt++;
        if ({start, busy, done} !== 3'b000) $display("FAIL reset_ctrl: %b required 000", {start, busy, done});
        else pass_cnt++;
        s0 = start_n;
        do_arm(1'b0);
        feed(100, 1'b0, 1'b0, acc, stray);
        check_cnt++;
        if (acc != 100) $display("FAIL reset_preload: accepted %0d required 100", acc);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        check_cnt++;
        if ({busy, bus.oREADY, bus.oWE} !== 6'd0)
            $display("FAIL reset_mid: busy/ready/we=%b required 0", {busy, bus.oREADY, bus.oWE});
        else pass_cnt++;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_cnt++;
        if (start_n != s0 || busy !== 1'b0 || bus.oREADY !== 1'b0)
            $display("FAIL reset_abort: starts=%0d busy=%b ready=%b required %0d 0 0", start_n, busy, bus.oREADY, s0);
        else pass_cnt++;
    endtask

    task automatic test_natural();
        int acc, stray, base;
        base = wr_n;
        do_arm(1'b0);
        feed(NSAMP, 1'b0, 1'b0, acc, stray);
        check_cnt++;
        if (acc != NSAMP || bus.oREADY !== 1'b0)
            $display("FAIL nat_accept: accepted %0d ready=%b required %0d 0", acc, bus.oREADY, NSAMP);
        else pass_cnt++;
        run_core(5, 1'b0, 1'b0);
        check_cnt++;
        if (wr_n - base != NSAMP) $display("FAIL nat_count: %0d writes required %0d", wr_n - base, NSAMP);
        else pass_cnt++;
        check_cnt++;
        if ({log_we[base], log_addr[base], log_data[base]} !== {4'b0001, 8'd0, 16'h0000})
            $display("FAIL nat_s0: %h required %h", {log_we[base], log_addr[base], log_data[base]}, {4'b0001, 8'd0, 16'h0000});
        else pass_cnt++;
        check_cnt++;
        if ({log_we[base+5], log_addr[base+5], log_data[base+5]} !== {4'b0010, 8'd1, 16'h0005})
            $display("FAIL nat_s5: %h required %h", {log_we[base+5], log_addr[base+5], log_data[base+5]}, {4'b0010, 8'd1, 16'h0005});
        else pass_cnt++;
        check_cnt++;
        if ({log_we[base+1023], log_addr[base+1023], log_data[base+1023]} !== {4'b1000, 8'd255, 16'h03FF})
            $display("FAIL nat_s1023: %h required %h", {log_we[base+1023], log_addr[base+1023], log_data[base+1023]}, {4'b1000, 8'd255, 16'h03FF});
        else pass_cnt++;
        check_cnt++;
        if (last_start_cyc != log_cyc[base+1023] + 1)
            $display("FAIL nat_start_timing: start cycle %0d required %0d", last_start_cyc, log_cyc[base+1023] + 1);
        else pass_cnt++;
    endtask

    task automatic test_bitrev();
        int acc, stray, base;
        logic [A_BIT-1:0] exp4, exp12;
`ifdef FHT_LOADER_BITREV_EN
        exp4 = 8'd128; exp12 = 8'd192;
`else
        exp4 = 8'd1;   exp12 = 8'd3;
`endif
        base = wr_n;
        do_arm(1'b1);
        feed(NSAMP, 1'b0, 1'b0, acc, stray);
        run_core(5, 1'b0, 1'b0);
        check_cnt++;
        if ({log_we[base+4], log_addr[base+4]} !== {4'b0001, exp4})
            $display("FAIL brev_s4: we/addr=%h required %h", {log_we[base+4], log_addr[base+4]}, {4'b0001, exp4});
        else pass_cnt++;
        check_cnt++;
        if ({log_we[base+12], log_addr[base+12]} !== {4'b0001, exp12})
            $display("FAIL brev_s12: we/addr=%h required %h", {log_we[base+12], log_addr[base+12]}, {4'b0001, exp12});
        else pass_cnt++;
    endtask

    task automatic test_sign_ext();
        int acc, stray, base;
        base = wr_n;
        do_arm(1'b0);
        feed(NSAMP, 1'b1, 1'b1, acc, stray);
        run_core(5, 1'b0, 1'b0);
        check_cnt++;
        if (acc != NSAMP || wr_n - base != NSAMP)
            $display("FAIL sx_count: accepted %0d writes %0d required %0d", acc, wr_n - base, NSAMP);
        else pass_cnt++;
        check_cnt++;
        if (stray != 0) $display("FAIL sx_stray: %0d writes after iVALID=0 required 0", stray);
        else pass_cnt++;
        check_cnt++;
        if ({log_data[base], log_data[base+1], log_data[base+2]} !== {16'hC000, 16'h3FFF, 16'h0002})
            $display("FAIL sx_data: %h required %h", {log_data[base], log_data[base+1], log_data[base+2]}, {16'hC000, 16'h3FFF, 16'h0002});
        else pass_cnt++;
        check_cnt++;
        if (log_cyc[base+1] - log_cyc[base] != 2)
            $display("FAIL sx_spacing: %0d cycles between writes required 2", log_cyc[base+1] - log_cyc[base]);
        else pass_cnt++;
    endtask

    task automatic test_handshake();
        int acc, stray, d0, s0;
        do_arm(1'b0);
        feed(NSAMP, 1'b0, 1'b0, acc, stray);
        d0 = done_n;
        s0 = start_n;
        run_core(50, 1'b1, 1'b0);
        check_cnt++;
        if (done_n != d0 + 1 || start_n != s0 + 1)
            $display("FAIL hs_pulses: done %0d start %0d required 1 1", done_n - d0, start_n - s0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acc, stray, base;
        do_arm(1'b0);
        feed(NSAMP, 1'b0, 1'b0, acc, stray);
        run_core(3, 1'b0, 1'b1);
        base = wr_n;
        feed(NSAMP, 1'b0, 1'b0, acc, stray);
        check_cnt++;
        if (acc != NSAMP) $display("FAIL b2b_accept: accepted %0d required %0d", acc, NSAMP);
        else pass_cnt++;
        check_cnt++;
        if ({log_we[base], log_addr[base], log_data[base]} !== {4'b0001, 8'd0, 16'h0000})
            $display("FAIL b2b_restart: %h required %h", {log_we[base], log_addr[base], log_data[base]}, {4'b0001, 8'd0, 16'h0000});
        else pass_cnt++;
        run_core(3, 1'b0, 1'b0);
    endtask

    initial begin
        bus.iVALID = 1'b0;
        bus.iDATA  = 15'h0000;
        test_reset();
        test_natural();
        test_bitrev();
        test_sign_ext();
        test_handshake();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
